// File: rtl/dvp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dvp_pkg
//  Description : Shared constants and types for the DVP camera emulator:
//                pattern mode encodings, YUV422 byte-order indices, neutral
//                chroma and green-box geometry/colour.
//  Revision    : 1.0 - initial release
// ============================================================================
package dvp_pkg;

    // Pattern select encodings; code 3 is reserved and renders as the ramp.
    typedef enum logic [1:0] {
        MODE_RAMP = 2'd0,
        MODE_BOX  = 2'd1,
        MODE_FLAT = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // Widths of the pixel-column and active-row indices fed to the generator.
    localparam int PX_W = 10;
    localparam int Y_W  = 9;

    // Chroma value that carries no colour.
    localparam logic [7:0] C_CHROMA_NEUTRAL = 8'd128;

    // Green box: inclusive bounds in pixel coordinates and its YCbCr colour.
    localparam logic [PX_W-1:0] C_BOX_X0 = 10'd256;
    localparam logic [PX_W-1:0] C_BOX_X1 = 10'd383;
    localparam logic [Y_W-1:0]  C_BOX_Y0 = 9'd176;
    localparam logic [Y_W-1:0]  C_BOX_Y1 = 9'd303;
    localparam logic [7:0]      C_BOX_LUMA   = 8'd150;
    localparam logic [7:0]      C_BOX_CHROMA = 8'd64;

    // Position of each component within a Cb Y0 Cr Y1 group.
    localparam logic [1:0] C_IDX_CB = 2'd0;
    localparam logic [1:0] C_IDX_Y0 = 2'd1;
    localparam logic [1:0] C_IDX_CR = 2'd2;
    localparam logic [1:0] C_IDX_Y1 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dvp_camera_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : dvp_camera_tx_if
//  Description : Pixel-port bundle of the camera emulator: frame controls
//                in, DVP sensor pins and frame counter out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dvp_camera_tx_if;
    logic       en;
    logic [1:0] mode;
    logic       PCLK;
    logic       VSYNC;
    logic       HREF;
    logic [7:0] D;
    logic [7:0] frame_cnt;

    // The emulator drives the sensor pins.
    modport master (
        input  en, mode,
        output PCLK, VSYNC, HREF, D, frame_cnt
    );

    // The capture side / controller.
    modport slave (
        output en, mode,
        input  PCLK, VSYNC, HREF, D, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dvp_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dvp_pattern_gen
//  Description : Combinational test-pattern source. Maps pattern mode,
//                pixel column, active row and byte position to one YUV422
//                byte (ramp, green box over ramp, or flat frame-count luma).
//  Revision    : 1.0 - initial release
// ============================================================================
module dvp_pattern_gen
    import dvp_pkg::*;
(
    input  mode_e           mode_i,
    input  logic [PX_W-1:0] px_i,
    input  logic [Y_W-1:0]  y_i,
    input  logic [1:0]      sel_i,
    input  logic [7:0]      frame_cnt_i,
    output logic [7:0]      byte_o
);

    logic       w_in_box;
    logic       w_is_luma;
    logic [7:0] w_luma;
    logic [7:0] w_chroma;

    assign w_in_box  = (px_i >= C_BOX_X0) && (px_i <= C_BOX_X1) &&
                       (y_i  >= C_BOX_Y0) && (y_i  <= C_BOX_Y1);
    assign w_is_luma = (sel_i == C_IDX_Y0) || (sel_i == C_IDX_Y1);

    // Pick luma/chroma for the selected pattern; the ramp is the fallback.
    always_comb begin
        w_luma   = px_i[PX_W-1:2];
        w_chroma = C_CHROMA_NEUTRAL;
        case (mode_i)
            MODE_BOX: begin
                if (w_in_box) begin
                    w_luma   = C_BOX_LUMA;
                    w_chroma = C_BOX_CHROMA;
                end
            end
            MODE_FLAT: w_luma = frame_cnt_i;
            default:   ;
        endcase
    end

    // Cb and Cr share one value in every pattern.
    assign byte_o = w_is_luma ? w_luma : w_chroma;

endmodule
`default_nettype wire

// File: rtl/dvp_camera_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dvp_camera_tx
//  Description : OV7670-style DVP source. Produces PCLK = CLOCK_24/2 and
//                registered VSYNC/HREF/D that change only on PCLK falling
//                edges, plus a completed-frame counter. en and mode are
//                taken only at the frame boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module dvp_camera_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic            CLOCK_24,
    input  logic            rst,
    dvp_camera_tx_if.master bus
);

    localparam int unsigned BYTES_PER_LINE = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned LINES          = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned ACTIVE_BYTES   = 2 * H_ACTIVE;
    localparam int unsigned V_START        = VS_LINES + V_BACK;
    localparam int unsigned V_END          = V_START + V_ACTIVE - 1;
    localparam int          BX_W           = $clog2(BYTES_PER_LINE);
    localparam int          LN_W           = $clog2(LINES);

    logic            ph_q,        ph_d;
    logic [BX_W-1:0] byte_x_q,    byte_x_d;
    logic [LN_W-1:0] line_q,      line_d;
    mode_e           mode_q,      mode_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            vsync_q,     vsync_d;
    logic            href_q,      href_d;
    logic [7:0]      d_q,         d_d;

    int unsigned     w_bx;
    int unsigned     w_ln;
    logic            w_boundary;
    logic            w_active;
    mode_e           w_mode;
    logic            w_vsync;
    logic            w_href;
    logic [PX_W-1:0] w_px;
    logic [Y_W-1:0]  w_y;
    logic [7:0]      w_byte;

    assign w_bx       = 32'(byte_x_q);
    assign w_ln       = 32'(line_q);
    // Counters rest at 0/0 both between frames and while idle, so this is
    // the only point where en and mode are looked at.
    assign w_boundary = (w_bx == 0) && (w_ln == 0);
    assign w_active   = !w_boundary || bus.en;
    assign w_mode     = w_boundary ? mode_e'(bus.mode) : mode_q;
    assign w_vsync    = (w_ln < 32'(VS_LINES));
    assign w_href     = (w_ln >= V_START) && (w_ln <= V_END) && (w_bx < ACTIVE_BYTES);
    assign w_px       = PX_W'(w_bx >> 1);
    // Only meaningful inside the active rows; D is forced to 0 elsewhere.
    assign w_y        = Y_W'(w_ln - V_START);

    dvp_pattern_gen u_pattern_gen (
        .mode_i      (w_mode),
        .px_i        (w_px),
        .y_i         (w_y),
        .sel_i       (byte_x_q[1:0]),
        .frame_cnt_i (frame_cnt_q),
        .byte_o      (w_byte)
    );

    // Slot sequencing: on each PCLK falling edge present the current slot
    // and step the byte/line/frame counters.
    always_comb begin
        ph_d        = ~ph_q;
        byte_x_d    = byte_x_q;
        line_d      = line_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        vsync_d     = vsync_q;
        href_d      = href_q;
        d_d         = d_q;
        if (ph_q) begin
            if (w_active) begin
                mode_d  = w_mode;
                vsync_d = w_vsync;
                href_d  = w_href;
                d_d     = w_href ? w_byte : 8'd0;
                if (w_bx == BYTES_PER_LINE - 1) begin
                    byte_x_d = '0;
                    if (w_ln == LINES - 1) begin
                        line_d      = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        line_d = line_q + LN_W'(1);
                    end
                end else begin
                    byte_x_d = byte_x_q + BX_W'(1);
                end
            end else begin
                vsync_d = 1'b0;
                href_d  = 1'b0;
                d_d     = 8'd0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK_24) begin
        if (rst) begin
            ph_q        <= 1'b0;
            byte_x_q    <= '0;
            line_q      <= '0;
            mode_q      <= MODE_RAMP;
            frame_cnt_q <= 8'd0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            d_q         <= 8'd0;
        end else begin
            ph_q        <= ph_d;
            byte_x_q    <= byte_x_d;
            line_q      <= line_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            d_q         <= d_d;
        end
    end

    assign bus.PCLK      = ph_q;
    assign bus.VSYNC     = vsync_q;
    assign bus.HREF      = href_q;
    assign bus.D         = d_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dvp_camera_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dvp_camera_tx
//  Description : Self-checking bench for dvp_camera_tx. One full-size
//                instance for frame timing, one reduced-size instance with a
//                slot-level scoreboard, and the pattern generator on its own
//                for the green-box geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dvp_camera_tx;
    import dvp_pkg::*;

    // Reduced geometry for the scoreboarded instance.
    localparam int SH  = 4;
    localparam int SHB = 2;
    localparam int SVS = 1;
    localparam int SVB = 1;
    localparam int SVA = 2;
    localparam int SVF = 1;
    localparam int SBPL   = 2 * SH + SHB;
    localparam int SLINES = SVS + SVB + SVA + SVF;

    // Full-size line period in cycles.
    localparam int LINE_CYC = 2 * (2 * 640 + 144);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    dvp_camera_tx_if ifa ();
    dvp_camera_tx_if ifb ();

    dvp_camera_tx u_a (
        .CLOCK_24 (clk),
        .rst      (rst_a),
        .bus      (ifa)
    );

    dvp_camera_tx #(
        .H_ACTIVE (SH),
        .V_ACTIVE (SVA),
        .H_BLANK  (SHB),
        .VS_LINES (SVS),
        .V_BACK   (SVB),
        .V_FRONT  (SVF)
    ) u_b (
        .CLOCK_24 (clk),
        .rst      (rst_b),
        .bus      (ifb)
    );

    mode_e      pg_mode;
    logic [9:0] pg_px;
    logic [8:0] pg_y;
    logic [1:0] pg_sel;
    logic [7:0] pg_fc;
    logic [7:0] pg_byte;

    dvp_pattern_gen u_pg (
        .mode_i      (pg_mode),
        .px_i        (pg_px),
        .y_i         (pg_y),
        .sel_i       (pg_sel),
        .frame_cnt_i (pg_fc),
        .byte_o      (pg_byte)
    );

    int checks = 0;
    int errors = 0;

    // Expected {PCLK, VSYNC, HREF, D} per slot, as seen at the PCLK rise.
    logic [10:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference for one slot of the reduced instance.
    function automatic logic [10:0] model_slot(input int line, input int bx, input int mode, input int fc);
        logic       vs;
        logic       hr;
        logic [7:0] d;
        int         px;
        int         y;
        logic       inbox;
        vs    = (line < SVS);
        hr    = (line >= SVS + SVB) && (line < SVS + SVB + SVA) && (bx < 2 * SH);
        px    = bx / 2;
        y     = line - (SVS + SVB);
        inbox = (px >= 256) && (px <= 383) && (y >= 176) && (y <= 303);
        d     = 8'd0;
        if (hr) begin
            if ((bx % 2) == 1) begin
                if (mode == 2)                d = 8'(fc);
                else if (mode == 1 && inbox)  d = 8'd150;
                else                          d = 8'(px / 4);
            end else begin
                d = (mode == 1 && inbox) ? 8'd64 : 8'd128;
            end
        end
        return {1'b1, vs, hr, d};
    endfunction

    task automatic push_frame(input int mode, input int fc);
        for (int ln = 0; ln < SLINES; ln++)
            for (int bx = 0; bx < SBPL; bx++)
                sb.push_back(model_slot(ln, bx, mode, fc));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++)
            sb.push_back(11'b100_0000_0000);
    endtask

    // Walk n slots; check the PCLK-low half and the PCLK-rise sample.
    task automatic run_slots(input int n);
        logic [10:0] exp;
        for (int i = 0; i < n; i++) begin
            step();
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
                return;
            end
            exp = sb[0];
            check("slot_lo", {ifb.PCLK, ifb.VSYNC, ifb.HREF, ifb.D}, {1'b0, exp[9:0]});
            step();
            exp = sb.pop_front();
            check("slot_rise", {ifb.PCLK, ifb.VSYNC, ifb.HREF, ifb.D}, exp);
        end
    endtask

    task automatic pg_check(input string tag, input mode_e m, input int px, input int y,
                            input int sel, input int fc, input int exp);
        pg_mode = m;
        pg_px   = 10'(px);
        pg_y    = 9'(y);
        pg_sel  = 2'(sel);
        pg_fc   = 8'(fc);
        #1;
        check(tag, 32'(pg_byte), 32'(exp));
    endtask

    initial begin
        int k;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        ifa.en   = 1'b1;
        ifa.mode = 2'd0;
        ifb.en   = 1'b1;
        ifb.mode = 2'd0;

        // ---- pattern generator: green box and its edges ----
        pg_check("box_cb",      MODE_BOX,  300, 200, 0, 0, 64);
        pg_check("box_y",       MODE_BOX,  300, 200, 1, 0, 150);
        pg_check("box_cr",      MODE_BOX,  300, 200, 2, 0, 64);
        pg_check("out_cb",      MODE_BOX,  100, 200, 0, 0, 128);
        pg_check("out_y",       MODE_BOX,  100, 200, 1, 0, 25);
        pg_check("out_cr",      MODE_BOX,  100, 200, 2, 0, 128);
        pg_check("box_x255",    MODE_BOX,  255, 200, 1, 0, 63);
        pg_check("box_x256",    MODE_BOX,  256, 200, 1, 0, 150);
        pg_check("box_corner",  MODE_BOX,  383, 303, 3, 0, 150);
        pg_check("box_x384",    MODE_BOX,  384, 200, 1, 0, 96);
        pg_check("box_y175",    MODE_BOX,  300, 175, 1, 0, 75);
        pg_check("box_y304",    MODE_BOX,  300, 304, 1, 0, 75);
        pg_check("ramp_y",      MODE_RAMP, 300, 200, 1, 0, 75);
        pg_check("rsvd_y",      MODE_RSVD, 300, 200, 3, 0, 75);
        pg_check("flat_y",      MODE_FLAT, 300, 200, 1, 7, 7);
        pg_check("flat_c",      MODE_FLAT, 300, 200, 2, 7, 128);

        // ---- reduced instance: reset state and first frame (ramp) ----
        repeat (4) step();
        check("b_reset", {ifb.PCLK, ifb.VSYNC, ifb.HREF, ifb.D, ifb.frame_cnt}, 32'd0);
        rst_b = 1'b0;
        step();
        check("b_k1", {ifb.PCLK, ifb.VSYNC, ifb.HREF, ifb.D}, {1'b1, 10'd0});
        push_frame(0, 0);
        run_slots(SBPL * SLINES);
        check("b_fc_f0", 32'(ifb.frame_cnt), 32'd1);

        // ---- flat frame; mode drops to ramp mid-frame, next frame ramps ----
        ifb.mode = 2'd2;
        push_frame(2, 1);
        run_slots(20);
        ifb.mode = 2'd0;
        run_slots(SBPL * SLINES - 20);
        check("b_fc_f1", 32'(ifb.frame_cnt), 32'd2);

        // ---- en dropped mid-frame: frame completes, then idle ----
        push_frame(0, 2);
        run_slots(10);
        ifb.en = 1'b0;
        run_slots(SBPL * SLINES - 10);
        check("b_fc_f2", 32'(ifb.frame_cnt), 32'd3);
        push_idle(6);
        run_slots(6);
        check("b_fc_idle", 32'(ifb.frame_cnt), 32'd3);

        // ---- en back: VSYNC rises on the very next slot ----
        ifb.en = 1'b1;
        push_frame(0, 3);
        run_slots(13);

        // ---- reset mid-line, then restart from scratch ----
        rst_b = 1'b1;
        step();
        check("b_rst_mid", {ifb.PCLK, ifb.VSYNC, ifb.HREF, ifb.D, ifb.frame_cnt}, 32'd0);
        sb.delete();
        rst_b = 1'b0;
        step();
        check("b_k1_again", {ifb.PCLK, ifb.VSYNC, ifb.HREF, ifb.D}, {1'b1, 10'd0});
        push_frame(0, 0);
        run_slots(SBPL * SLINES);
        check("b_fc_restart", 32'(ifb.frame_cnt), 32'd1);

        // ---- full-size instance: frame timing ----
        check("a_reset", {ifa.PCLK, ifa.VSYNC, ifa.HREF, ifa.D, ifa.frame_cnt}, 32'd0);
        rst_a = 1'b0;
        step();
        check("a_k1", {ifa.PCLK, ifa.VSYNC}, {1'b1, 1'b0});
        step();
        check("a_k2", {ifa.PCLK, ifa.VSYNC}, {1'b0, 1'b1});
        k = 2;
        while (ifa.VSYNC && k < 10000) begin
            step();
            k++;
        end
        check("a_vs_fall_k", 32'(k), 32'(2 + 3 * LINE_CYC));
        while (!ifa.HREF && k < 60000) begin
            step();
            k++;
        end
        check("a_href_rise_k", 32'(k), 32'(2 + 20 * LINE_CYC));
        check("a_first_cb", 32'(ifa.D), 32'd128);
        step(); step();
        check("a_first_y0", 32'(ifa.D), 32'd0);
        step(); step();
        check("a_first_cr", 32'(ifa.D), 32'd128);

        // ---- full-size instance: reset mid-line and restart ----
        repeat (101) step();
        rst_a = 1'b1;
        step();
        check("a_rst_mid", {ifa.PCLK, ifa.VSYNC, ifa.HREF, ifa.D, ifa.frame_cnt}, 32'd0);
        rst_a = 1'b0;
        step();
        check("a_k1_again", {ifa.PCLK, ifa.VSYNC}, {1'b1, 1'b0});
        step();
        check("a_k2_again", {ifa.PCLK, ifa.VSYNC}, {1'b0, 1'b1});
        k = 2;
        while (ifa.VSYNC && k < 10000) begin
            step();
            k++;
        end
        check("a_vs_fall_again", 32'(k), 32'(2 + 3 * LINE_CYC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
